// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, types and sizing helper for the debounce bank
package debounce_pkg;

  localparam int DB_STABLE_DEFAULT = 8;
  localparam int DB_LONG_DEFAULT   = 0;

  // Prescaler divide ratio that turns the system clock into a 1 kHz sample tick.
  localparam int DB_CLK_HZ       = 50_000_000;
  localparam int DB_SAMPLE_HZ    = 1_000;
  localparam int DB_PRESCALE_DIV = DB_CLK_HZ / DB_SAMPLE_HZ;

  typedef struct packed {
    logic clean;
    logic rise;
    logic fall;
    logic long_press;
  } db_chan_out_t;

  // Bits needed to hold 0..max_count; never less than one bit.
  function automatic int db_cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced input: synchroniser, stability counter, edge and long-press pulses
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DB_STABLE_DEFAULT,
  parameter int   LONG_CYCLES   = DB_LONG_DEFAULT,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sample_en_i,
  input  logic         noisy_i,
  output db_chan_out_t out_o
);

  localparam int CW = db_cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic          clean_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, fall_q;
  logic          long_press;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= noisy_i;
      sync2_q <= sync1_q;
    end
  end

  // Any sample agreeing with the current clean level restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sample_en_i) begin
      if (sync2_q == clean_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // clean_dly_q runs every clk, so edge pulses stay one clk wide under a slow tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      clean_q     <= RESET_LEVEL;
      clean_dly_q <= RESET_LEVEL;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      rise_q      <= clean_q & ~clean_dly_q;
      fall_q      <= ~clean_q & clean_dly_q;
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int HW = db_cnt_width(LONG_CYCLES);
      localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          long_q, long_d;

      // Clearing on clean_d lets a coinciding release suppress the long-press pulse.
      always_comb begin
        hcnt_d = hcnt_q;
        if (!clean_d) begin
          hcnt_d = '0;
        end else if (clean_q && sample_en_i && (hcnt_q != HOLD_MAX)) begin
          hcnt_d = hcnt_q + 1'b1;
        end
        long_d = (hcnt_d == HOLD_MAX) && (hcnt_q != HOLD_MAX);
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          hcnt_q <= '0;
          long_q <= 1'b0;
        end else begin
          hcnt_q <= hcnt_d;
          long_q <= long_d;
        end
      end

      assign long_press = long_q;
    end else begin : g_no_long
      assign long_press = 1'b0;
    end
  endgenerate

  assign out_o.clean      = clean_q;
  assign out_o.rise       = rise_q;
  assign out_o.fall       = fall_q;
  assign out_o.long_press = long_press;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N_CH independent debounce channels sharing one sample tick
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N_CH          = 4,
  parameter int   STABLE_CYCLES = DB_STABLE_DEFAULT,
  parameter int   LONG_CYCLES   = DB_LONG_DEFAULT,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      db_chan_out_t ch_out;

      debounce_channel #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES),
        .RESET_LEVEL  (RESET_LEVEL)
      ) u_ch (
        .clk_i      (clk),
        .rst_i      (rst),
        .sample_en_i(sample_en),
        .noisy_i    (noisy[i]),
        .out_o      (ch_out)
      );

      assign clean[i]      = ch_out.clean;
      assign rise[i]       = ch_out.rise;
      assign fall[i]       = ch_out.fall;
      assign long_press[i] = ch_out.long_press;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank with a behavioural reference model
module tb_debounce_bank;

  localparam int STABLE = 8;
  localparam int LONG   = 32;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic [3:0] noisy;
  logic [3:0] clean, rise, fall, long_press;

  int tests = 0;
  int fails = 0;

  debounce_bank #(
    .N_CH(4), .STABLE_CYCLES(STABLE), .LONG_CYCLES(LONG), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .noisy(noisy),
    .clean(clean), .rise(rise), .fall(fall), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a 2-deep delay line, a run length of disagreeing ticks,
  // and a held-tick count; pulses are reported one clock after the level moves.
  logic [3:0] m_d1, m_d2, m_clean, m_rise, m_fall, m_long, pend_r, pend_f;
  int         run_len[4];
  int         hold[4];
  logic       was;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_clean = '0;
      m_rise = '0; m_fall = '0; m_long = '0; pend_r = '0; pend_f = '0;
      for (int c = 0; c < 4; c++) begin
        run_len[c] = 0;
        hold[c]    = 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        m_rise[c] = pend_r[c];
        m_fall[c] = pend_f[c];
        was = m_clean[c];
        if (sample_en) begin
          if (m_d2[c] == m_clean[c]) run_len[c] = 0;
          else begin
            run_len[c] = run_len[c] + 1;
            if (run_len[c] == STABLE) begin
              m_clean[c] = m_d2[c];
              run_len[c] = 0;
            end
          end
        end
        pend_r[c] = !was && m_clean[c];
        pend_f[c] = was && !m_clean[c];
        m_long[c] = 1'b0;
        if (!m_clean[c]) hold[c] = 0;
        else if (was && sample_en && hold[c] < LONG) begin
          hold[c] = hold[c] + 1;
          m_long[c] = (hold[c] == LONG);
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = noisy[c];
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; noisy = 4'b0000; sample_en = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({clean, rise, fall, long_press} !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0000", {clean, rise, fall, long_press});
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      tests++;
      if ({clean, rise, fall, long_press} !== 16'h0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: got %h want 0000", k, {clean, rise, fall, long_press});
      end
    end
  endtask

  task automatic test_step();
    logic [3:0] exp_c, exp_r;
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) noisy[0] = 1'b1;
      @(negedge clk);
      exp_c = (k >= 10) ? 4'b0001 : 4'b0000;
      exp_r = (k == 11) ? 4'b0001 : 4'b0000;
      tests++;
      if ({clean, rise} !== {exp_c, exp_r}) begin
        fails++;
        $display("FAIL step edge%0d: clean/rise got %b/%b want %b/%b", k, clean, rise, exp_c, exp_r);
      end
      tests++;
      if ({clean, rise, fall, long_press} !== {m_clean, m_rise, m_fall, m_long}) begin
        fails++;
        $display("FAIL step_model edge%0d: got %h want %h", k, {clean, rise, fall, long_press}, {m_clean, m_rise, m_fall, m_long});
      end
    end
  endtask

  task automatic test_toggle();
    int k_up = -1;
    for (int k = 0; k < 100; k++) begin
      if (k % 5 == 0) noisy[1] = ~noisy[1];
      @(negedge clk);
      tests++;
      if ({clean[1], rise[1], fall[1]} !== 3'b000) begin
        fails++;
        $display("FAIL toggle cyc%0d: clean/rise/fall[1] got %b want 000", k, {clean[1], rise[1], fall[1]});
      end
    end
    noisy[1] = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) noisy[1] = 1'b1;
      @(negedge clk);
      if (clean[1] && k_up < 0) k_up = k;
      tests++;
      if ({clean, rise, fall, long_press} !== {m_clean, m_rise, m_fall, m_long}) begin
        fails++;
        $display("FAIL toggle_model edge%0d: got %h want %h", k, {clean, rise, fall, long_press}, {m_clean, m_rise, m_fall, m_long});
      end
    end
    tests++;
    if (k_up !== 10) begin
      fails++;
      $display("FAIL toggle_hold_latency: got edge %0d want 10", k_up);
    end
  endtask

  task automatic test_long_press();
    int k_up = -1, k_dn = -1, k_long = -1;
    int n_rise = 0, n_fall = 0, n_long = 0;
    for (int k = 1; k <= 85; k++) begin
      if (k == 1)  noisy[2] = 1'b1;
      if (k == 61) noisy[2] = 1'b0;
      @(negedge clk);
      if (clean[2] && k_up < 0) k_up = k;
      if (!clean[2] && k_up > 0 && k_dn < 0) k_dn = k;
      if (rise[2]) n_rise++;
      if (fall[2]) n_fall++;
      if (long_press[2]) begin n_long++; k_long = k; end
      tests++;
      if ({clean, rise, fall, long_press} !== {m_clean, m_rise, m_fall, m_long}) begin
        fails++;
        $display("FAIL long_model edge%0d: got %h want %h", k, {clean, rise, fall, long_press}, {m_clean, m_rise, m_fall, m_long});
      end
    end
    tests++;
    if (k_up !== 10)  begin fails++; $display("FAIL long_clean_up: got edge %0d want 10", k_up); end
    tests++;
    if (n_rise !== 1) begin fails++; $display("FAIL long_rise_count: got %0d want 1", n_rise); end
    tests++;
    if (n_long !== 1) begin fails++; $display("FAIL long_press_count: got %0d want 1", n_long); end
    tests++;
    if (k_long !== 42) begin fails++; $display("FAIL long_press_edge: got %0d want 42", k_long); end
    tests++;
    if (k_dn !== 70)  begin fails++; $display("FAIL long_clean_down: got edge %0d want 70", k_dn); end
    tests++;
    if (n_fall !== 1) begin fails++; $display("FAIL long_fall_count: got %0d want 1", n_fall); end
  endtask

  task automatic test_slow_tick();
    int k_up = -1, n_rise = 0;
    for (int k = 1; k <= 44; k++) begin
      if (k == 1) noisy[3] = 1'b1;
      sample_en = (k % 4 == 0);
      @(negedge clk);
      if (clean[3] && k_up < 0) k_up = k;
      if (rise[3]) n_rise++;
      tests++;
      if ({clean, rise, fall, long_press} !== {m_clean, m_rise, m_fall, m_long}) begin
        fails++;
        $display("FAIL slow_model edge%0d: got %h want %h", k, {clean, rise, fall, long_press}, {m_clean, m_rise, m_fall, m_long});
      end
    end
    sample_en = 1'b1;
    tests++;
    if (k_up !== 32)  begin fails++; $display("FAIL slow_latency: got edge %0d want 32", k_up); end
    tests++;
    if (n_rise !== 1) begin fails++; $display("FAIL slow_rise_width: got %0d cycles want 1", n_rise); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_c, exp_r;
    noisy[0] = 1'b0;
    repeat (20) @(negedge clk);
    noisy[0] = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (clean !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_clean: got %b want 0000", clean);
    end
    repeat (2) begin
      @(negedge clk);
      tests++;
      if ({clean, rise, fall, long_press} !== 16'h0) begin
        fails++;
        $display("FAIL reset_mid_hold: got %h want 0000", {clean, rise, fall, long_press});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_c = (k >= 10) ? (noisy & 4'b1011) : 4'b0000;
      exp_r = (k == 11) ? (noisy & 4'b1011) : 4'b0000;
      tests++;
      if ({clean, rise, fall, long_press} !== {exp_c, exp_r, 8'h00}) begin
        fails++;
        $display("FAIL reset_mid_relatch edge%0d: got %h want %h", k, {clean, rise, fall, long_press}, {exp_c, exp_r, 8'h00});
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 9) == 0) noisy[c] = ~noisy[c];
      sample_en = ($urandom_range(0, 3) != 0);
      rst = (k == 1500);
      @(negedge clk);
      tests++;
      if ({clean, rise, fall, long_press} !== {m_clean, m_rise, m_fall, m_long}) begin
        fails++;
        $display("FAIL random cyc%0d: got %h want %h", k, {clean, rise, fall, long_press}, {m_clean, m_rise, m_fall, m_long});
      end
    end
    rst = 1'b0;
    sample_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_step();
    test_toggle();
    test_long_press();
    test_slow_tick();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel debouncer for push-buttons and switches. It replaces the single-bit 3-sample debouncer.
- Each channel has:
  - a 2-flop synchroniser,
  - a programmable-length stability counter,
  - press/release edge pulses,
  - an optional long-press detector.
- It sits between the raw board inputs and the scheduling control FSM. The FSM consumes single-cycle events, not levels.

Parameters:
- N_CH, 4: number of independent channels.
- STABLE_CYCLES, 8: consecutive sample ticks an input must differ from the current clean level before clean follows it. Range 1..65535.
- LONG_CYCLES, 0: sample ticks clean must stay 1 before long_press fires. 0 disables long-press; the logic is removed and the output is tied 0.
- RESET_LEVEL, 0: reset value of clean and of both synchroniser flops, applied to all channels.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  sample tick from the prescaler. Tie to 1 for per-clock sampling.
- noisy  in  N_CH  raw asynchronous inputs.
- clean  out  N_CH  debounced level.
- rise  out  N_CH  one-clk pulse when clean goes 0->1.
- fall  out  N_CH  one-clk pulse when clean goes 1->0.
- long_press  out  N_CH  one-clk pulse when clean has been 1 for LONG_CYCLES ticks.

Behaviour:
- Reset (async assert, sync-safe deassert upstream):
  - sync flops = RESET_LEVEL, clean = RESET_LEVEL.
  - All counters = 0.
  - rise/fall/long_press = 0.
  - No pulses are generated by the reset release itself.
- Synchroniser:
  - s[i] = noisy[i] after 2 clk flops, clocked every clk regardless of sample_en.
- Stability counter cnt[i], width $clog2(STABLE_CYCLES+1). It updates only on cycles with sample_en=1:
  - If s==clean: cnt <= 0 (any glitch restarts the count).
  - Else if cnt == STABLE_CYCLES-1: clean <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - With sample_en=0, cnt and clean hold.
- Latency with sample_en=1 and a clean step on noisy:
  - Number the clk edge that first samples the new level as edge 1.
  - clean changes at edge STABLE_CYCLES+2.
  - Any reversion of s before that edge aborts the change.
- Edge pulses:
  - rise[i]/fall[i] are registered. They assert for exactly one clk in the cycle after clean changes, and are 0 otherwise.
  - The pulse is one clk wide even when sample_en is a slow tick.
- Long press (LONG_CYCLES>0), hold counter hcnt[i], width $clog2(LONG_CYCLES+1):
  - While clean==1, it increments on sample_en and saturates at LONG_CYCLES.
  - long_press pulses for one clk when hcnt reaches LONG_CYCLES, and only once per press.
  - hcnt clears to 0 in the same cycle clean becomes 0.
  - If release and the long threshold coincide, the release wins and no long_press is generated.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset mid-count: all counters clear, clean returns to RESET_LEVEL, and no pulse is generated.
- No combinational paths from noisy to any output. All outputs are registered.

Decomposition:
- Shared package/header `debounce_pkg`:
  - Default constants DB_STABLE_DEFAULT and DB_LONG_DEFAULT.
  - Prescaler divide constant for a 1 kHz sample tick.
  - Counter width function (clog2 wrapper).
- Sub-module `debounce_channel`: one synchroniser, stability counter, edge and long-press logic.
  - Instantiated N_CH times in a generate loop by debounce_bank.
  - debounce_bank itself contains only the generate loop and port slicing.

Test Plan (N_CH=4, STABLE_CYCLES=8, LONG_CYCLES=32, sample_en=1 unless noted):
1. Reset, then noisy=4'b0000 held for 50 clk -> clean=0, no rise/fall/long_press at any cycle, including the rst deassert cycle.
2. noisy[0] steps 0->1 and holds -> clean[0]=1 at edge 10; rise[0]=1 for exactly one clk on the following cycle; other channels unchanged.
3. noisy[1] toggles every 5 clk for 100 clk -> clean[1] stays 0, rise[1]/fall[1] never assert. Then holding noisy[1]=1 gives clean[1]=1 after 10 edges.
4. noisy[2] held 1 for 60 clk, then 0 -> rise[2] once; long_press[2] exactly once, 32 clk after clean[2] rose; fall[2] once, 10 edges after release.
5. sample_en pulses every 4th clk, noisy[3] step to 1 -> clean[3] changes after 8 sample ticks (about 32–36 clk); rise[3] is one clk wide.
6. rst asserted while cnt[0]=5 mid-transition -> clean=0 immediately. After release, a fresh 10-edge latency applies and no spurious pulses occur.
